blit_ramarb_n: RTL and testbench
================================

Name: blit_ramarb_n

Overview:
- N-channel successor to the two-port CPU/display RAM arbiter: any number of bus masters (CPU, display DMA, blitter, debug) share one req/ack RAM port.
- Two priority classes, set by parameter. Round-robin within each class. A starvation counter guarantees the low class eventually gets service.
- Sits between the bus and display DMA on the master side and blit_ram on the slave side. One RAM transaction is outstanding at a time.

Parameters:
- NCH, 3, number of master channels (2..8)
- AW, 18, word address width
- DW, 16, data width (multiple of 8)
- HIPRI, 3'b010, bitmask of high-class channels (default: channel 1 = display DMA)
- STARVE, 4, consecutive high-class grants allowed while a low-class request waits (0 disables the starvation override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req  in  NCH  per-channel request level
- m_addr  in  NCH*AW  channel i at [i*AW +: AW]
- m_wdata  in  NCH*DW  channel i at [i*DW +: DW]
- m_wstrb  in  NCH*DW/8  byte strobes per channel
- m_we  in  NCH  write enable per channel
- m_ack  out  NCH  one-cycle completion pulse, at most one bit set
- m_rdata  out  DW  read data, valid in the cycle m_ack is high
- ram_req  out  1  RAM request level
- ram_addr  out  AW  registered address
- ram_wdata  out  DW  registered write data
- ram_wstrb  out  DW/8  registered strobes
- ram_we  out  1  registered write enable
- ram_ack  in  1  RAM completion pulse
- ram_rdata  in  DW  RAM read data, valid with ram_ack
- grant  out  3  index of the current or last granted channel (debug)
- busy  out  1  high in the BUSY state

Behaviour:
- Reset values:
  - state IDLE; all outputs 0 (ram_req, ram_addr, ram_wdata, ram_wstrb, ram_we, m_ack, m_rdata, grant, busy)
  - rr pointers hi_ptr = lo_ptr = NCH-1
  - starve_cnt = 0
- Master contract: hold m_req and its payload stable until that channel's m_ack. The master may drop or re-raise m_req the cycle after m_ack.
- States: IDLE, BUSY, GAP.
- IDLE:
  - pending = m_req.
  - If pending is nonzero: pick winner g, latch ram_* from channel g, set ram_req=1, grant=g, busy=1, go to BUSY.
  - If pending is zero: stay in IDLE.
- Winner selection:
  - hp = pending & HIPRI; lp = pending & ~HIPRI.
  - Force low class if lp is nonzero, STARVE is nonzero and starve_cnt ≥ STARVE.
  - Otherwise high class wins if hp is nonzero, else low class.
  - Within a class, take the first set bit searching upward cyclically from that class's pointer + 1.
  - Update the winning class's pointer to g.
- starve_cnt update on each grant:
  - high-class grant while lp is nonzero: increment, saturating at 15
  - low-class grant, or lp is zero: reset to 0
- BUSY:
  - Hold ram_req and ram_* stable until ram_ack.
  - On ram_ack: ram_req=0, m_ack[g]=1 for one cycle, m_rdata=ram_rdata (registered, also on writes), go to GAP.
  - Waiting is unbounded; no timeout.
- GAP:
  - Lasts one cycle. m_req is ignored so a stale request from the just-acked master is not re-granted. busy=0.
  - Go to IDLE.
- Latency with a zero-wait RAM:
  - req sampled at cycle 0 → ram_req high at cycle 1 → ram_ack at cycle 1 earliest → m_ack at cycle 2.
  - Back-to-back grants every 3 cycles minimum.
- m_ack is never asserted outside BUSY→GAP. A ram_ack arriving in IDLE or GAP is ignored.
- A request dropped mid-BUSY (protocol violation) still completes; m_ack is still pulsed.
- rst mid-BUSY: ram_req drops the following cycle and no m_ack is issued. The transaction is lost, so masters are reset together with the arbiter.
- Simultaneous requests in the same cycle resolve purely by class, then rr pointer. There is no tie beyond that.

Test Plan:
- Single read: ch0 req, addr 0x00100, RAM acks 2 cycles after ram_req with 0xBEEF → ram_addr=0x00100, ram_we=0; m_ack[0] one cycle later with m_rdata=0xBEEF; nothing else pulses.
- Class priority: ch0 and ch1 request in the same cycle → ch1 (HIPRI) granted first; ch0 granted after the GAP; grant shows 1 then 0.
- Round-robin: ch0 and ch2 (both low) request continuously, zero-wait RAM → grant sequence 0,2,0,2…; period 3 cycles per grant.
- Starvation: ch1 requests continuously, ch0 requests continuously, STARVE=4 → grants 1,1,1,1,0,1,1,1,1,0…; with STARVE=0, ch0 is never granted.
- Write path: ch2 writes addr 0x3FFFF, data 0x1234, wstrb 2'b10 → ram_* carry exactly these values and stay stable until ram_ack; m_ack[2] follows.
- Reset mid-op: rst asserted while BUSY with the RAM stalled → next cycle ram_req=0, busy=0, no m_ack; a late ram_ack after reset produces no m_ack; the next request is served normally.

Source files
------------

// File: rtl/blit_ramarb_n.sv
// blit_ramarb_n: N-channel two-class round-robin arbiter onto a single req/ack RAM port
// Low class is forced through after STARVE consecutive high-class grants that left it waiting.
module blit_ramarb_n #(
    parameter int NCH    = 3,
    parameter int AW     = 18,
    parameter int DW     = 16,
    parameter int HIPRI  = 3'b010,
    parameter int STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH*AW-1:0]     m_addr,
    input  logic [NCH*DW-1:0]     m_wdata,
    input  logic [NCH*DW/8-1:0]   m_wstrb,
    input  logic [NCH-1:0]        m_we,
    output logic [NCH-1:0]        m_ack,
    output logic [DW-1:0]         m_rdata,
    output logic                  ram_req,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_wdata,
    output logic [DW/8-1:0]       ram_wstrb,
    output logic                  ram_we,
    input  logic                  ram_ack,
    input  logic [DW-1:0]         ram_rdata,
    output logic [2:0]            grant,
    output logic                  busy
);
    localparam int SW = DW / 8;
    localparam logic [NCH-1:0] HI = NCH'(HIPRI);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           ram_req_q, ram_we_q;
    logic [AW-1:0]  ram_addr_q;
    logic [DW-1:0]  ram_wdata_q, m_rdata_q;
    logic [SW-1:0]  ram_wstrb_q;
    logic [NCH-1:0] m_ack_q, hp, lp;
    logic [2:0]     grant_q, hi_ptr_q, lo_ptr_q, g;
    logic [3:0]     starve_q;
    logic           use_lo;

    // first set bit of v searching upward cyclically from ptr+1
    function automatic logic [2:0] pick(input logic [NCH-1:0] v, input logic [2:0] ptr);
        int j;
        pick = ptr;
        for (int k = NCH; k >= 1; k--) begin
            j = (int'(ptr) + k) % NCH;
            if (|(v & (NCH'(1) << j))) pick = 3'(j);
        end
    endfunction

    always_comb begin
        hp      = m_req & HI;
        lp      = m_req & ~HI;
        use_lo  = (|lp && STARVE != 0 && int'(starve_q) >= STARVE) || hp == '0;
        g       = use_lo ? pick(lp, lo_ptr_q) : pick(hp, hi_ptr_q);
        state_d = state_q == IDLE ? (|m_req ? BUSY : IDLE) :
                  state_q == BUSY ? (ram_ack ? GAP : BUSY) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wstrb_q <= '0;
            ram_we_q    <= 1'b0;
            m_ack_q     <= '0;
            m_rdata_q   <= '0;
            grant_q     <= '0;
            hi_ptr_q    <= 3'(NCH - 1);
            lo_ptr_q    <= 3'(NCH - 1);
            starve_q    <= '0;
        end else begin
            state_q <= state_d;
            m_ack_q <= '0;
            if (state_q == IDLE && |m_req) begin
                grant_q     <= g;
                ram_req_q   <= 1'b1;
                ram_addr_q  <= AW'(m_addr >> (int'(g) * AW));
                ram_wdata_q <= DW'(m_wdata >> (int'(g) * DW));
                ram_wstrb_q <= SW'(m_wstrb >> (int'(g) * SW));
                ram_we_q    <= |(m_we & (NCH'(1) << g));
                if (use_lo) lo_ptr_q <= g;
                else hi_ptr_q <= g;
                starve_q    <= (!use_lo && |lp) ? starve_q + (starve_q != 4'hF ? 4'd1 : 4'd0) : 4'd0;
            end
            if (state_q == BUSY && ram_ack) begin
                ram_req_q <= 1'b0;
                m_ack_q   <= NCH'(1) << grant_q;
                m_rdata_q <= ram_rdata;
            end
        end
    end

    assign m_ack     = m_ack_q;
    assign m_rdata   = m_rdata_q;
    assign ram_req   = ram_req_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wstrb = ram_wstrb_q;
    assign ram_we    = ram_we_q;
    assign grant     = grant_q;
    assign busy      = state_q == BUSY;
endmodule

// File: tb/tb_blit_ramarb_n.sv
// tb_blit_ramarb_n: directed checks of the N-channel RAM arbiter
module tb_blit_ramarb_n;
    localparam int NCH = 3, AW = 18, DW = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [NCH-1:0] m_req = '0, m_we = '0;
    logic [NCH*AW-1:0] m_addr = '0;
    logic [NCH*DW-1:0] m_wdata = '0;
    logic [NCH*DW/8-1:0] m_wstrb = '0;
    logic auto_ack = 1'b0, man_ack = 1'b0;
    logic [DW-1:0] ram_rdata = '0;

    logic [NCH-1:0] m_ack, m_ack2;
    logic [DW-1:0] m_rdata, m_rdata2, ram_wdata, ram_wdata2;
    logic ram_req, ram_req2, ram_we, ram_we2, ram_ack, ram_ack2, busy, busy2;
    logic [AW-1:0] ram_addr, ram_addr2;
    logic [DW/8-1:0] ram_wstrb, ram_wstrb2;
    logic [2:0] grant, grant2;

    int total = 0, bad = 0, cyc = 0, lo2 = 0, hi2 = 0;
    logic cnt_en = 1'b0;

    assign ram_ack  = auto_ack ? ram_req : man_ack;
    assign ram_ack2 = ram_req2;

    blit_ramarb_n dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_we(m_we), .m_ack(m_ack), .m_rdata(m_rdata),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_we(ram_we), .ram_ack(ram_ack),
        .ram_rdata(ram_rdata), .grant(grant), .busy(busy)
    );

    blit_ramarb_n #(.STARVE(0)) dut_ns (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_we(m_we), .m_ack(m_ack2), .m_rdata(m_rdata2),
        .ram_req(ram_req2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_wstrb(ram_wstrb2), .ram_we(ram_we2), .ram_ack(ram_ack2),
        .ram_rdata(ram_rdata), .grant(grant2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_en && m_ack2[0]) lo2 <= lo2 + 1;
        if (cnt_en && m_ack2[1]) hi2 <= hi2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req = '0;
        m_we = '0;
        auto_ack = 1'b0;
        man_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // bounded wait for the next m_ack pulse; ch stays -1 on timeout
    task automatic wait_ack(output int ch, output int at);
        ch = -1;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_ack != '0) begin
                for (int j = 0; j < NCH; j++) if (m_ack == 3'(1 << j)) ch = j;
                if (ch == -1) ch = 99;
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int ch, at, prev;
        int exp_st[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset();
        chk("rst_ram_req", int'(ram_req), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        chk("rst_ram_wstrb", int'(ram_wstrb), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_m_ack", int'(m_ack), 0);
        chk("rst_m_rdata", int'(m_rdata), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);

        // single read, RAM acks two cycles after ram_req
        m_addr[0 +: AW] = 18'h00100;
        m_req = 3'b001;
        tick();
        chk("rd_ram_req", int'(ram_req), 1);
        chk("rd_ram_addr", int'(ram_addr), 'h100);
        chk("rd_ram_we", int'(ram_we), 0);
        chk("rd_grant", int'(grant), 0);
        chk("rd_busy", int'(busy), 1);
        chk("rd_no_ack_early", int'(m_ack), 0);
        tick();
        chk("rd_req_held", int'(ram_req), 1);
        chk("rd_no_ack_wait", int'(m_ack), 0);
        man_ack = 1'b1;
        ram_rdata = 16'hBEEF;
        tick();
        chk("rd_m_ack", int'(m_ack), 'b001);
        chk("rd_m_rdata", int'(m_rdata), 'hBEEF);
        chk("rd_req_drop", int'(ram_req), 0);
        chk("rd_gap_busy", int'(busy), 0);
        man_ack = 1'b0;
        m_req = '0;
        ram_rdata = '0;
        tick();
        chk("rd_ack_once", int'(m_ack), 0);
        chk("rd_rdata_hold", int'(m_rdata), 'hBEEF);

        // class priority
        do_reset();
        auto_ack = 1'b1;
        m_req = 3'b011;
        wait_ack(ch, at);
        chk("pri_first", ch, 1);
        chk("pri_grant1", int'(grant), 1);
        m_req[1] = 1'b0;
        wait_ack(ch, at);
        chk("pri_second", ch, 0);
        chk("pri_grant0", int'(grant), 0);
        m_req = '0;

        // round-robin within low class, zero-wait RAM
        do_reset();
        auto_ack = 1'b1;
        m_req = 3'b101;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(ch, at);
            chk("rr_grant", ch, (k % 2 == 0) ? 0 : 2);
            if (k > 0) chk("rr_period", at - prev, 3);
            prev = at;
        end
        m_req = '0;

        // starvation override, with a STARVE=0 twin watched alongside
        do_reset();
        auto_ack = 1'b1;
        cnt_en = 1'b1;
        m_req = 3'b011;
        for (int k = 0; k < 10; k++) begin
            wait_ack(ch, at);
            chk("starve_seq", ch, exp_st[k]);
        end
        cnt_en = 1'b0;
        m_req = '0;
        chk("nostarve_lo", lo2, 0);
        chk("nostarve_hi", int'(hi2 >= 8), 1);

        // write path with a stalled RAM
        do_reset();
        m_addr[2*AW +: AW] = 18'h3FFFF;
        m_wdata[2*DW +: DW] = 16'h1234;
        m_wstrb[4 +: 2] = 2'b10;
        m_we = 3'b100;
        m_req = 3'b100;
        tick();
        chk("wr_grant", int'(grant), 2);
        for (int k = 0; k < 3; k++) begin
            chk("wr_req", int'(ram_req), 1);
            chk("wr_addr", int'(ram_addr), 'h3FFFF);
            chk("wr_wdata", int'(ram_wdata), 'h1234);
            chk("wr_wstrb", int'(ram_wstrb), 'b10);
            chk("wr_we", int'(ram_we), 1);
            chk("wr_no_ack", int'(m_ack), 0);
            tick();
        end
        man_ack = 1'b1;
        tick();
        chk("wr_m_ack", int'(m_ack), 'b100);
        chk("wr_req_drop", int'(ram_req), 0);
        man_ack = 1'b0;
        m_req = '0;
        m_we = '0;

        // reset while BUSY, then a late ack, then normal service
        do_reset();
        m_req = 3'b001;
        tick();
        chk("mid_busy", int'(busy), 1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_ram_req", int'(ram_req), 0);
        chk("mid_busy_clr", int'(busy), 0);
        chk("mid_no_ack", int'(m_ack), 0);
        rst = 1'b0;
        m_req = '0;
        man_ack = 1'b1;
        tick();
        chk("late_ack0", int'(m_ack), 0);
        tick();
        chk("late_ack1", int'(m_ack), 0);
        man_ack = 1'b0;
        ram_rdata = 16'hCAFE;
        auto_ack = 1'b1;
        m_req = 3'b100;
        wait_ack(ch, at);
        chk("post_rst_ch", ch, 2);
        chk("post_rst_rdata", int'(m_rdata), 'hCAFE);
        m_req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
